// File: rtl/div_seq.sv
// Sequential 16-bit restoring divider: one quotient bit per cycle via an external subtractor.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX state for the sign correction).
module div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic [15:0] sub_a,
  output logic [15:0] sub_b,
  input  logic [15:0] sub_diff,
  input  logic        sub_carry
);

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t      state;
  logic [15:0] d_reg;
  logic [15:0] q_reg;
  logic [15:0] r_reg;
  logic [3:0]  cnt;
  logic [16:0] shifted;
  logic        accept;
  logic [15:0] r_next;
  logic [15:0] q_next;
  logic [15:0] cap_a;
  logic [15:0] cap_b;
  logic        can_start;
`ifdef DIV_SIGNED_EN
  logic        neg_q;
  logic        neg_r;
`endif

  // S[16] set means S already exceeds D, so the subtraction is taken even without carry.
  always_comb begin
    shifted = {r_reg, q_reg[15]};
    accept  = sub_carry | shifted[16];
    r_next  = accept ? sub_diff : shifted[15:0];
    q_next  = {q_reg[14:0], accept};
  end

  always_comb begin
`ifdef DIV_SIGNED_EN
    cap_a = dividend[15] ? (~dividend + 16'd1) : dividend;
    cap_b = divisor[15]  ? (~divisor + 16'd1)  : divisor;
`else
    cap_a = dividend;
    cap_b = divisor;
`endif
  end

  assign sub_a = shifted[15:0];
  assign sub_b = d_reg;

  // The done cycle accepts a new start so back-to-back divisions need no idle gap.
  assign can_start = start && ((state == IDLE) || ((state == DONE) && done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 16'd0;
      remainder   <= 16'd0;
      div_by_zero <= 1'b0;
      d_reg       <= 16'd0;
      q_reg       <= 16'd0;
      r_reg       <= 16'd0;
      cnt         <= 4'd0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15) begin
`ifdef DIV_SIGNED_EN
            state <= FIX;
`else
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          quotient    <= neg_q ? (~q_reg + 16'd1) : q_reg;
          remainder   <= neg_r ? (~r_reg + 16'd1) : r_reg;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
`endif
        // A divide-by-zero enters DONE with done low and pulses it one cycle later.
        DONE: begin
          if (!done) done <= 1'b1;
          else       state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (can_start) begin
        if (divisor == 16'd0) begin
          state       <= DONE;
          busy        <= 1'b0;
          quotient    <= 16'hFFFF;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
          d_reg <= cap_b;
          q_reg <= cap_a;
          r_reg <= 16'd0;
          cnt   <= 4'd0;
`ifdef DIV_SIGNED_EN
          neg_q <= dividend[15] ^ divisor[15];
          neg_r <= dividend[15];
`endif
        end
      end
    end
  end

endmodule
